// File: rtl/hilo_muldiv_if.sv
// Handshake, operand and HI/LO access bundle for the hilo_muldiv engine.
// The pipeline drives the master side; the engine sits on the slave side.
interface hilo_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             mthi_we;
    logic             mtlo_we;
    logic [WIDTH-1:0] wdata;
    logic             rd_sel;
    logic [WIDTH-1:0] rd;

    modport master (
        output en, start, op, a, b, mthi_we, mtlo_we, wdata, rd_sel,
        input  busy, done, rd
    );

    modport slave (
        input  en, start, op, a, b, mthi_we, mtlo_we, wdata, rd_sel,
        output busy, done, rd
    );
endinterface

// File: rtl/hilo_muldiv.sv
// HI/LO register pair with an iterative radix-2 multiply/divide engine
// (shift-add multiply, restoring divide on magnitudes, sign fix at commit).
module hilo_muldiv #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    hilo_muldiv_if.slave  bus
);
    localparam logic [WIDTH-1:0]   ONE_W  = WIDTH'(1);
    localparam logic [2*WIDTH-1:0] ONE_2W = (2*WIDTH)'(1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd_b;
    logic             is_div;
    logic             neg_q;
    logic             neg_r;
    logic             div_zero;

    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sh_rem;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   nxt_hi;
    logic [WIDTH-1:0]   nxt_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    logic op_signed;
    logic mt_any;
    logic accept;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + ONE_W) : v;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? (~v + ONE_W) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
        return neg ? (~v + ONE_2W) : v;
    endfunction

    assign op_signed = bus.op[0];
    assign mt_any    = bus.mthi_we | bus.mtlo_we;
    assign accept    = bus.en && (state == IDLE) && bus.start;

    // One radix-2 step; division tests the shifted remainder against the divisor.
    always_comb begin
        add_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd_b : '0)};
        sh_rem  = {acc_hi, acc_lo[WIDTH-1]};
        diff    = sh_rem - {1'b0, opnd_b};
        nxt_hi  = add_sum[WIDTH:1];
        nxt_lo  = {add_sum[0], acc_lo[WIDTH-1:1]};
        if (is_div) begin
            if (!diff[WIDTH]) begin
                nxt_hi = diff[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = sh_rem[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Sign fix applied to the final step's result; a zero divisor forces an all-ones quotient.
    always_comb begin
        prod   = cond_neg_2w({nxt_hi, nxt_lo}, neg_q);
        res_hi = prod[2*WIDTH-1:WIDTH];
        res_lo = prod[WIDTH-1:0];
        if (is_div) begin
            res_lo = div_zero ? '1 : cond_neg(nxt_lo, neg_q);
            res_hi = cond_neg(nxt_hi, neg_r);
        end
    end

    // Operand magnitudes and working registers carry no reset; state gates their use.
    always_ff @(posedge clk) begin
        if (bus.en) begin
            if (accept) begin
                acc_hi   <= '0;
                acc_lo   <= magnitude(bus.a, op_signed);
                opnd_b   <= magnitude(bus.b, op_signed);
                is_div   <= bus.op[1];
                neg_q    <= op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_r    <= op_signed & bus.a[WIDTH-1];
                div_zero <= (bus.b == '0);
            end else if (state == RUN) begin
                acc_hi <= nxt_hi;
                acc_lo <= nxt_lo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else if (bus.en) begin
            done_r <= 1'b0;
            if (bus.mthi_we) hi <= bus.wdata;
            if (bus.mtlo_we) lo <= bus.wdata;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= RUN;
                        busy_r <= 1'b1;
                        cnt    <= CNT_W'(WIDTH);
                    end
                end
                RUN: begin
                    if (mt_any) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            hi     <= res_hi;
                            lo     <= res_lo;
                            state  <= IDLE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;

    // A same-cycle MTHI/MTLO write is forwarded to the read port.
    always_comb begin
        if (bus.rd_sel)
            bus.rd = (bus.mthi_we && bus.en) ? bus.wdata : hi;
        else
            bus.rd = (bus.mtlo_we && bus.en) ? bus.wdata : lo;
    end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Randomized and directed bench for hilo_muldiv against a plain-arithmetic
// HI/LO reference model.
module tb_hilo_muldiv;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    hilo_muldiv_if #(.WIDTH(W)) bus();

    hilo_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] p;
        longint      sp;
        int          sa;
        int          sb;
        sa = $signed(a);
        sb = $signed(b);
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin
                p  = {32'h0, a} * {32'h0, b};
                hi = p[63:32];
                lo = p[31:0];
            end
            2'b01: begin
                sp = longint'(sa) * longint'(sb);
                p  = 64'(sp);
                hi = p[63:32];
                lo = p[31:0];
            end
            2'b10: begin
                if (b == 0) begin lo = '1; hi = a; end
                else begin lo = a / b; hi = a % b; end
            end
            default: begin
                if (b == 0) begin lo = '1; hi = a; end
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin lo = 32'h8000_0000; hi = 0; end
                else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
            end
        endcase
    endfunction

    task automatic read_regs(output logic [31:0] hi, output logic [31:0] lo);
        bus.rd_sel = 1'b1;
        #1 hi = bus.rd;
        bus.rd_sel = 1'b0;
        #1 lo = bus.rd;
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int busy_cnt, output int done_cyc);
        busy_cnt = 0;
        done_cyc = 0;
        for (int k = 1; k <= 200; k++) begin
            if (bus.done) begin
                done_cyc = k;
                break;
            end
            if (bus.busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [31:0] h, l;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
        read_regs(h, l);
        checks++; if (h !== 32'h0) begin errors++; $display("FAIL reset_hi got=%h want=0", h); end
        checks++; if (l !== 32'h0) begin errors++; $display("FAIL reset_lo got=%h want=0", l); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_multu_max();
        int bc, dc;
        logic [31:0] h, l;
        @(negedge clk);
        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(bc, dc);
        checks++; if (bc !== 32) begin errors++; $display("FAIL multu_busy_cycles got=%0d want=32", bc); end
        checks++; if (dc !== 33) begin errors++; $display("FAIL multu_done_cycle got=%0d want=33", dc); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL multu_busy_in_done got=%b want=0", bus.busy); end
        read_regs(h, l);
        checks++; if (h !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got=%h want=fffffffe", h); end
        checks++; if (l !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo got=%h want=00000001", l); end
        @(negedge clk);
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got=%b want=0", bus.done); end
    endtask

    task automatic test_signed_ops();
        logic [1:0]  ops [4]  = '{2'b01, 2'b11, 2'b10, 2'b11};
        logic [31:0] as  [4]  = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h7, 32'h8000_0000};
        logic [31:0] bs  [4]  = '{32'h5, 32'h2, 32'h0, 32'hFFFF_FFFF};
        logic [31:0] ehs [4]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7, 32'h0};
        logic [31:0] els [4]  = '{32'hFFFF_FFF1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000};
        int bc, dc;
        logic [31:0] h, l;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            launch(ops[i], as[i], bs[i]);
            wait_done(bc, dc);
            checks++; if (dc !== 33) begin errors++; $display("FAIL dir%0d_latency got=%0d want=33", i, dc); end
            read_regs(h, l);
            checks++; if (h !== ehs[i]) begin errors++; $display("FAIL dir%0d_hi got=%h want=%h", i, h, ehs[i]); end
            checks++; if (l !== els[i]) begin errors++; $display("FAIL dir%0d_lo got=%h want=%h", i, l, els[i]); end
        end
    endtask

    task automatic test_en_freeze();
        int dc;
        logic [31:0] h, l;
        @(negedge clk);
        bus.mthi_we = 1'b1;
        bus.wdata   = 32'h5A5A_5A5A;
        @(negedge clk);
        bus.mthi_we = 1'b0;
        launch(2'b00, 32'd3, 32'd4);
        dc = 0;
        for (int k = 1; k <= 200; k++) begin
            if (bus.done) begin dc = k; break; end
            if (k >= 10 && k <= 14) begin
                bus.en = 1'b0; bus.mthi_we = 1'b1; bus.wdata = 32'h0000_DEAD; bus.rd_sel = 1'b1;
            end else begin
                bus.en = 1'b1; bus.mthi_we = 1'b0;
            end
            if (k == 12) begin
                #1;
                checks++; if (bus.rd !== 32'h5A5A_5A5A) begin errors++; $display("FAIL en_low_no_bypass got=%h want=5a5a5a5a", bus.rd); end
                checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL en_low_busy_hold got=%b want=1", bus.busy); end
            end
            @(negedge clk);
        end
        bus.en = 1'b1;
        bus.mthi_we = 1'b0;
        checks++; if (dc !== 38) begin errors++; $display("FAIL en_low_done_cycle got=%0d want=38", dc); end
        read_regs(h, l);
        checks++; if (h !== 32'h0) begin errors++; $display("FAIL en_low_hi got=%h want=0", h); end
        checks++; if (l !== 32'd12) begin errors++; $display("FAIL en_low_lo got=%h want=c", l); end
    endtask

    task automatic test_mt_abort();
        int seen;
        logic [31:0] h, l;
        @(negedge clk);
        bus.mthi_we = 1'b1;
        bus.wdata   = 32'h0BAD_F00D;
        @(negedge clk);
        bus.mthi_we = 1'b0;
        launch(2'b10, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        bus.mtlo_we = 1'b1;
        bus.wdata   = 32'h0000_1234;
        bus.rd_sel  = 1'b0;
        #1;
        checks++; if (bus.rd !== 32'h0000_1234) begin errors++; $display("FAIL abort_bypass got=%h want=00001234", bus.rd); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got=%b want=1", bus.busy); end
        @(negedge clk);
        bus.mtlo_we = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy_after got=%b want=0", bus.busy); end
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done || bus.busy) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got=%0d cycles want=0", seen); end
        read_regs(h, l);
        checks++; if (l !== 32'h0000_1234) begin errors++; $display("FAIL abort_lo got=%h want=00001234", l); end
        checks++; if (h !== 32'h0BAD_F00D) begin errors++; $display("FAIL abort_hi got=%h want=0badf00d", h); end
    endtask

    task automatic test_mt_with_start();
        int bc, dc;
        logic [31:0] h, l;
        @(negedge clk);
        bus.mthi_we = 1'b1;
        bus.mtlo_we = 1'b1;
        bus.wdata   = 32'hCAFE_0001;
        bus.start   = 1'b1;
        bus.op      = 2'b00;
        bus.a       = 32'd2;
        bus.b       = 32'd3;
        bus.rd_sel  = 1'b1;
        #1;
        checks++; if (bus.rd !== 32'hCAFE_0001) begin errors++; $display("FAIL both_we_bypass_hi got=%h want=cafe0001", bus.rd); end
        @(negedge clk);
        bus.mthi_we = 1'b0;
        bus.mtlo_we = 1'b0;
        bus.start   = 1'b0;
        read_regs(h, l);
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mt_start_accepted got=%b want=1", bus.busy); end
        checks++; if (h !== 32'hCAFE_0001 || l !== 32'hCAFE_0001) begin errors++; $display("FAIL both_we_write got=%h/%h want=cafe0001", h, l); end
        wait_done(bc, dc);
        read_regs(h, l);
        checks++; if (h !== 32'h0 || l !== 32'd6) begin errors++; $display("FAIL mt_start_commit got=%h/%h want=0/6", h, l); end
    endtask

    task automatic test_reset_mid();
        int bc, dc, seen;
        logic [31:0] h, l;
        @(negedge clk);
        launch(2'b01, 32'hFFFF_FFFB, 32'd9);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b want=0", bus.busy); end
        read_regs(h, l);
        checks++; if (h !== 32'h0 || l !== 32'h0) begin errors++; $display("FAIL rst_mid_regs got=%h/%h want=0/0", h, l); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done || bus.busy) seen++;
            @(negedge clk);
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_no_done got=%0d cycles want=0", seen); end
        launch(2'b00, 32'd6, 32'd7);
        wait_done(bc, dc);
        checks++; if (dc !== 33) begin errors++; $display("FAIL rst_restart_latency got=%0d want=33", dc); end
        read_regs(h, l);
        checks++; if (h !== 32'h0 || l !== 32'd42) begin errors++; $display("FAIL rst_restart_result got=%h/%h want=0/2a", h, l); end
    endtask

    task automatic test_back_to_back();
        int bc, dc;
        logic [31:0] h, l, eh, el, a2, b2;
        @(negedge clk);
        launch(2'b11, 32'hFFFF_FF00, 32'd10);
        wait_done(bc, dc);
        read_regs(h, l);
        ref_model(2'b11, 32'hFFFF_FF00, 32'd10, eh, el);
        checks++; if (h !== eh || l !== el) begin errors++; $display("FAIL b2b_first got=%h/%h want=%h/%h", h, l, eh, el); end
        a2 = $urandom;
        b2 = $urandom;
        launch(2'b01, a2, b2);
        wait_done(bc, dc);
        checks++; if (dc !== 33) begin errors++; $display("FAIL b2b_second_latency got=%0d want=33", dc); end
        read_regs(h, l);
        ref_model(2'b01, a2, b2, eh, el);
        checks++; if (h !== eh || l !== el) begin errors++; $display("FAIL b2b_second got=%h/%h want=%h/%h", h, l, eh, el); end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h1;
            default: return $urandom;
        endcase
    endfunction

    task automatic test_random();
        int bc, dc;
        logic [1:0]  op;
        logic [31:0] a, b, h, l, eh, el;
        for (int i = 0; i < 24; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick_operand();
            b  = pick_operand();
            @(negedge clk);
            launch(op, a, b);
            wait_done(bc, dc);
            checks++; if (dc !== 33) begin errors++; $display("FAIL rnd%0d_latency got=%0d want=33", i, dc); end
            read_regs(h, l);
            ref_model(op, a, b, eh, el);
            checks++; if (h !== eh) begin errors++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, h, eh); end
            checks++; if (l !== el) begin errors++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, l, el); end
        end
    endtask

    initial begin
        bus.en      = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.a       = '0;
        bus.b       = '0;
        bus.mthi_we = 1'b0;
        bus.mtlo_we = 1'b0;
        bus.wdata   = '0;
        bus.rd_sel  = 1'b0;
        rst_n       = 1'b0;
        test_reset();
        test_multu_max();
        test_signed_ops();
        test_en_freeze();
        test_mt_abort();
        test_mt_with_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Parametrised HI/LO register pair with an integrated iterative multiply/divide engine. It is the successor to the plain HI/LO holding register in the EX stage of the pipelined MIPS datapath. It executes MULT/MULTU/DIV/DIVU over WIDTH cycles with a start/busy/done handshake and commits both halves of the result atomically. It also serves MTHI/MTLO writes and MFHI/MFLO reads with same-cycle bypass.

## Interface
- WIDTH, 32, operand and HI/LO register width (even, >= 4)
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  stage enable; low freezes all state (engine, HI/LO, done)
- start  in  1  launch operation (accepted only in IDLE with en=1)
- op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- a  in  WIDTH  multiplicand / dividend (rs)
- b  in  WIDTH  multiplier / divisor (rt)
- busy  out  1  engine running
- done  out  1  one-cycle pulse after result commit
- mthi_we  in  1  write wdata to HI
- mtlo_we  in  1  write wdata to LO
- wdata  in  WIDTH  MTHI/MTLO data
- rd_sel  in  1  0 = read LO, 1 = read HI
- rd  out  WIDTH  selected register value

## Operation
- States: IDLE, RUN.
- In IDLE with start=1 and en=1:
  - latch operand magnitudes (two's-complement absolute values for signed ops) and result signs;
  - load the counter with WIDTH;
  - go to RUN.
- RUN: one radix-2 step per enabled cycle (shift-add multiply, restoring divide); the counter decrements each step.
- Final step (counter 1 -> 0): apply the sign fix, write HI and LO in the same edge, return to IDLE, and set done for the next cycle.
- Multiply: the 2*WIDTH product is the signed or unsigned product. HI = upper half, LO = lower half.
- Divide: LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
- Divide by zero (b=0, DIV or DIVU): no trap, full latency, LO = all ones, HI = a unchanged.
- Signed overflow (DIV most-negative / -1): LO = most-negative, HI = 0.
- start while busy: ignored. start with en=0: ignored.
- MTHI/MTLO (en=1): write wdata on the edge. Both asserted together: both registers are written.
- MTHI/MTLO while busy: abort the operation. Return to IDLE the next edge, no commit, no done; the mt write takes effect.
- MTHI/MTLO with start in IDLE: the write takes effect and start is accepted; the later commit overwrites both registers.
- rd: purely combinational (no latch) = rd_sel ? HI : LO.
  - Bypass: if the matching we (mthi_we for HI, mtlo_we for LO) is high and en=1, rd = wdata.
  - While busy, rd shows the last committed value.

## Timing
- Reset (async, rst_n=0):
  - HI = 0, LO = 0, state IDLE, counter 0, busy = 0, done = 0, rd = 0 (absent bypass);
  - an in-flight operation is discarded.
- start sampled at edge E0. busy = 1 from after E0 through E_WIDTH, i.e. WIDTH cycles.
- HI/LO written at E_WIDTH. done = 1 for exactly the cycle after E_WIDTH. busy = 0 in that cycle.
- A new start is accepted in the done cycle (back-to-back throughput: one operation per WIDTH+1 cycles).
- en=0 cycles:
  - no step, no counter change, no HI/LO write;
  - busy and done hold their values;
  - each such cycle adds one cycle to the latency.
- Abort: busy falls on the edge that samples mthi_we/mtlo_we.

## Test plan
- Reset, then MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy high 32 cycles, done on cycle 33, HI=0xFFFFFFFE, LO=0x00000001.
- Signed multiply and divide:
  - MULT a=0xFFFFFFFD (-3) b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1.
  - DIV a=0xFFFFFFF9 (-7) b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Division corner cases:
  - DIVU a=7 b=0 -> LO=0xFFFFFFFF, HI=7, latency 32.
  - DIV a=0x80000000 b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- en low with MTHI:
  - start MULTU 3*4, drop en for 5 cycles mid-run with mthi_we=1 -> done on cycle 38, HI=0, LO=12, MTHI ignored.
- mtlo during busy:
  - mtlo_we=1 wdata=0x1234 at cycle 10 of DIVU -> busy low next cycle, no done, LO=0x1234, HI unchanged.
  - With rd_sel=0 in that cycle -> rd=0x1234 (bypass).
- Reset mid-operation:
  - rst_n low at cycle 20 of MULT -> HI=LO=0, busy=0 immediately.
  - No done after release.
  - Then start is accepted normally.
